// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Buffered UART transmitter. Words arrive on a valid/ready stream, are held in
// a FIFO_DEPTH-entry FIFO, and are sent one frame each:
//     start bit (0), DATA_BITS data bits LSB first, optional parity bit,
//     STOP_BITS stop bits (1).
// Frames are emitted back to back with no idle clock in between while words
// remain queued. The bit time is sampled from clks_per_bit when a word is
// popped, so a divisor change only affects the following frame.
//
// Parameters
//   DATA_BITS   data bits per frame (5..9)
//   FIFO_DEPTH  buffered words (power of 2, >= 2)
//   PARITY      0 = none, 1 = even, 2 = odd
//   STOP_BITS   1 or 2
//   DIV_W       width of the baud divisor
//
// Ports
//   clk           system clock
//   rstn          asynchronous active-low reset
//   s_valid       input word valid
//   s_data        input word
//   s_ready       FIFO can accept a word (not full)
//   clks_per_bit  clocks per bit; 0 behaves as 1
//   tx            serial output, idle high, registered
//   busy          frame in progress or FIFO not empty
//   fifo_level    number of words currently held in the FIFO
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        s_valid,
    input  logic [DATA_BITS-1:0]        s_data,
    output logic                        s_ready,
    input  logic [DIV_W-1:0]            clks_per_bit,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int BCW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [LW-1:0]        count_q;
    logic [LW-1:0]        count_d;

    // Transmitter state
    state_t               state_q;
    state_t               state_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic                 par_q;
    logic                 par_d;
    logic [DIV_W-1:0]     div_q;
    logic [DIV_W-1:0]     div_d;
    logic [DIV_W-1:0]     div_cnt_q;
    logic [DIV_W-1:0]     div_cnt_d;
    logic [BCW-1:0]       bit_cnt_q;
    logic [BCW-1:0]       bit_cnt_d;
    logic                 tx_q;
    logic                 tx_d;

    logic push;
    logic pop;
    logic fifo_nonempty;
    logic bit_tick;
    logic last_stop;

    assign s_ready       = (count_q < LW'(FIFO_DEPTH));
    assign push          = s_valid && s_ready;
    assign fifo_nonempty = (count_q != '0);
    // Last clock of the current bit time.
    assign bit_tick      = (div_cnt_q == div_q - DIV_W'(1));
    assign last_stop     = (bit_cnt_q == BCW'(STOP_BITS - 1));

    // A word is taken from the FIFO either from idle, or on the very last
    // clock of the final stop bit so the next start bit follows with no gap.
    assign pop = fifo_nonempty &&
                 ((state_q == S_IDLE) ||
                  ((state_q == S_STOP) && bit_tick && last_stop));

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE) || fifo_nonempty;
    assign fifo_level = count_q;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    // Storage has no reset so it maps onto distributed/block RAM; the only
    // read is the registered load into the shift register.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        par_d     = par_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = ((state_q == S_IDLE) || bit_tick) ? '0 : div_cnt_q + DIV_W'(1);
        tx_d      = 1'b1;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
            end
            S_START: begin
                tx_d = 1'b0;
                if (bit_tick) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    par_d   = par_q ^ shift_q[0];
                    if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            S_PARITY: begin
                tx_d = par_q;
                if (bit_tick) begin
                    state_d   = S_STOP;
                    bit_cnt_d = '0;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_tick) begin
                    if (last_stop) begin
                        state_d   = S_IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Loading a new word overrides whatever the state above decided.
        // Parity is accumulated while shifting; odd parity starts from 1.
        if (pop) begin
            state_d   = S_START;
            shift_d   = mem_q[rd_ptr_q];
            par_d     = (PARITY == 2);
            div_d     = (clks_per_bit == '0) ? DIV_W'(1) : clks_per_bit;
            div_cnt_d = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            par_q     <= 1'b0;
            div_q     <= DIV_W'(1);
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            div_q     <= div_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
        end
    end

endmodule
